gpio_poller: RTL
================

# gpio_poller

Autonomous bus initiator that drives the same single-cycle memory-mapped bus the CPU uses toward the data RAM and GPIO register map (DDR at 0x80, PORT at 0x81, PIN at 0x82, RAM below 0x80). On `start` it programs DDR and PORT, then polls PIN at a fixed interval. Each change of the pin value is logged as one word into a ring buffer in data RAM, so software can inspect pin history without busy-waiting. It sits beside the CPU on the data-memory bus; arbitration is outside this block.

## Interface
- `WIDTH`, 32, data and address width.
- `RAM_BASE`, 'h40, word address of ring buffer slot 0.
- `RAM_WORDS`, 16, ring depth in words; power of two, ≥2. `RAM_BASE+RAM_WORDS` ≤ 'h80.
- `POLL_DIV`, 4, WAIT cycles between PIN reads; ≥1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a session; honoured only in IDLE.
- `stop`  in  1  end the session; level, sampled each cycle.
- `cfg_ddr`  in  WIDTH  value written to DDR at session start.
- `cfg_port`  in  WIDTH  value written to PORT at session start.
- `bus_addr`  out  WIDTH  word address.
- `bus_we`  out  1  write strobe, one cycle per write.
- `bus_wd`  out  WIDTH  write data.
- `bus_rd`  in  WIDTH  read data; combinational from `bus_addr`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `last_pin`  out  WIDTH  most recent PIN sample.
- `wptr`  out  log2(RAM_WORDS)  next ring slot to write.
- `event_cnt`  out  WIDTH  logged events since last start; saturates at all-ones.
- `overflow`  out  1  sticky; ring wrapped since last start.

## Operation
- States: IDLE, CFG_DDR, CFG_PORT, WAIT, READ, LOG.
- IDLE: bus idle (`bus_addr`=0, `bus_we`=0, `bus_wd`=0). If `start`=1 and `stop`=0: clear `wptr`, `event_cnt`, `overflow`, and the baseline-valid flag, then go to CFG_DDR. If `start` and `stop` are both high, `stop` wins and the block stays in IDLE.
- CFG_DDR: `bus_addr`='h80, `bus_we`=1, `bus_wd`=`cfg_ddr`, then go to CFG_PORT.
- CFG_PORT: `bus_addr`='h81, `bus_we`=1, `bus_wd`=`cfg_port`, then go to WAIT with the divider loaded to POLL_DIV-1.
- WAIT: bus idle. Exit to IDLE if `stop` is high or a stop is pending. Otherwise count down, and go to READ when the divider reaches 0.
- READ: `bus_addr`='h82, `bus_we`=0; capture `bus_rd` at the clock edge.
  - No baseline yet: store it in `last_pin`, set baseline-valid, go to WAIT. Nothing is logged.
  - Value ≠ `last_pin`: update `last_pin`, go to LOG.
  - Otherwise: go to WAIT.
- LOG: `bus_addr`=`RAM_BASE`+`wptr`, `bus_we`=1, `bus_wd`=`last_pin`. At the clock edge:
  - `wptr` increments modulo RAM_WORDS.
  - `event_cnt` increments, saturating.
  - `overflow` is set when `wptr` wraps from RAM_WORDS-1 to 0.
  - Then go to WAIT.
- `stop` seen in CFG_DDR, CFG_PORT, READ or LOG sets the stop-pending flag. The current bus cycle and any LOG it triggers still complete, and exit happens at the next WAIT. The flag clears on entry to IDLE.
- Every WAIT entry reloads the divider to POLL_DIV-1.
- `last_pin`, `wptr`, `event_cnt` and `overflow` hold their values in IDLE until the next start.

## Timing
- Reset: state IDLE. All outputs 0: `bus_addr`, `bus_we`, `bus_wd`, `busy`, `last_pin`, `wptr`, `event_cnt`, `overflow`. Bus outputs drop to 0 asynchronously on `rst` assertion.
- Reset mid-operation aborts immediately. A write in flight is dropped, because `bus_we` falls before the next edge.
- Bus outputs are registered state decodes, stable for a whole cycle; exactly one bus cycle per non-WAIT state.
- `start` high at edge N puts CFG_DDR on the bus in cycle N+1 and CFG_PORT in N+2. WAIT occupies N+3 … N+2+POLL_DIV, so the first READ is in cycle N+3+POLL_DIV.
- Poll period is POLL_DIV+1 cycles without a change and POLL_DIV+2 with a LOG.
- The GPIO PIN register lags the pads by 2 cycles. Pulses shorter than the poll period may be missed; that is by design.
- `busy` falls one cycle after WAIT observes a stop.

## Test plan
- Reset mid-LOG: assert `rst` while `bus_we`=1 → all outputs 0 within the same cycle; no RAM write; IDLE.
- Configure: `cfg_ddr`='hFF, `cfg_port`='hA5, pulse `start` → write 'h80←'hFF, then 'h81←'hA5, `busy`=1. With POLL_DIV=4, the first read of 'h82 occurs 5 cycles after the start edge plus 2 more.
- Change logging: steady PIN='h0F, then switch to 'hF0 → exactly one write of 'hF0 to 'h40; `event_cnt`=1, `wptr`=1. The baseline 'h0F is not logged.
- Wrap: 17 changes with RAM_WORDS=16 → 17th write lands at 'h40; `wptr`=1, `overflow`=1, `event_cnt`=17.
- Stop during READ with a pending change → LOG still written, `busy`=0 one cycle after the following WAIT. A later `start` clears `overflow`, `event_cnt` and `wptr`.
- `start` and `stop` high together in IDLE → no bus activity, `busy` stays 0.

Source files
------------

// File: rtl/gpio_poller_if.sv
// gpio_poller_if
//   Single-cycle memory-mapped data bus shared with the CPU toward data RAM
//   and the GPIO register map.
//   bus_addr : word address            (initiator -> target)
//   bus_we   : one-cycle write strobe  (initiator -> target)
//   bus_wd   : write data              (initiator -> target)
//   bus_rd   : read data, combinational from bus_addr (target -> initiator)
interface gpio_poller_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] bus_addr;
    logic             bus_we;
    logic [WIDTH-1:0] bus_wd;
    logic [WIDTH-1:0] bus_rd;

    modport master (
        output bus_addr,
        output bus_we,
        output bus_wd,
        input  bus_rd
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  bus_wd,
        output bus_rd
    );
endinterface

// File: rtl/gpio_poller.sv
// gpio_poller
//   Autonomous bus initiator. On start it writes DDR (0x80) and PORT (0x81),
//   then polls PIN (0x82) every POLL_DIV+1 cycles. Every change of the pin
//   value is appended to a ring buffer in data RAM at RAM_BASE.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start, stop      : session control (start honoured in IDLE, stop is a level)
//   cfg_ddr/cfg_port : values written to DDR/PORT at session start
//   bus              : memory-mapped bus (master side)
//   busy             : high whenever not IDLE
//   last_pin         : most recent PIN sample
//   wptr             : next ring slot to write
//   event_cnt        : logged events since last start, saturating
//   overflow         : sticky, ring wrapped since last start
module gpio_poller #(
    parameter int WIDTH     = 32,
    parameter int RAM_BASE  = 'h40,
    parameter int RAM_WORDS = 16,
    parameter int POLL_DIV  = 4,
    localparam int AW       = $clog2(RAM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_ddr,
    input  logic [WIDTH-1:0] cfg_port,
    gpio_poller_if.master    bus,
    output logic             busy,
    output logic [WIDTH-1:0] last_pin,
    output logic [AW-1:0]    wptr,
    output logic [WIDTH-1:0] event_cnt,
    output logic             overflow
);
    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(POLL_DIV - 1);
    localparam logic [AW-1:0]    WPTR_LAST = AW'(RAM_WORDS - 1);

    localparam logic [WIDTH-1:0] ADDR_DDR  = WIDTH'('h80);
    localparam logic [WIDTH-1:0] ADDR_PORT = WIDTH'('h81);
    localparam logic [WIDTH-1:0] ADDR_PIN  = WIDTH'('h82);

    typedef enum logic [2:0] {
        IDLE,
        CFG_DDR,
        CFG_PORT,
        WAIT,
        READ,
        LOG
    } state_t;

    state_t           state_reg,     state_next;
    logic [DIV_W-1:0] div_reg,       div_next;
    logic [AW-1:0]    wptr_reg,      wptr_next;
    logic [WIDTH-1:0] cnt_reg,       cnt_next;
    logic             ovf_reg,       ovf_next;
    logic [WIDTH-1:0] pin_reg,       pin_next;
    logic             base_reg,      base_next;
    logic             stop_pend_reg, stop_pend_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            wptr_reg      <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            pin_reg       <= '0;
            base_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            wptr_reg      <= wptr_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            pin_reg       <= pin_next;
            base_reg      <= base_next;
            stop_pend_reg <= stop_pend_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        wptr_next      = wptr_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        pin_next       = pin_reg;
        base_next      = base_reg;
        stop_pend_next = stop_pend_reg;

        case (state_reg)
            IDLE: begin
                stop_pend_next = 1'b0;
                // stop has priority over start so software can hold the block off
                if (start && !stop) begin
                    wptr_next  = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    base_next  = 1'b0;
                    state_next = CFG_DDR;
                end
            end
            CFG_DDR: begin
                if (stop) stop_pend_next = 1'b1;
                state_next = CFG_PORT;
            end
            CFG_PORT: begin
                if (stop) stop_pend_next = 1'b1;
                div_next   = DIV_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                // WAIT is the only exit point, so a started bus cycle or LOG
                // is never cut short by stop
                if (stop || stop_pend_reg) begin
                    stop_pend_next = 1'b0;
                    state_next     = IDLE;
                end else if (div_reg == '0) begin
                    state_next = READ;
                end else begin
                    div_next = div_reg - DIV_W'(1);
                end
            end
            READ: begin
                if (stop) stop_pend_next = 1'b1;
                if (!base_reg) begin
                    // first sample of a session only establishes the baseline
                    pin_next   = bus.bus_rd;
                    base_next  = 1'b1;
                    div_next   = DIV_LOAD;
                    state_next = WAIT;
                end else if (bus.bus_rd != pin_reg) begin
                    pin_next   = bus.bus_rd;
                    state_next = LOG;
                end else begin
                    div_next   = DIV_LOAD;
                    state_next = WAIT;
                end
            end
            LOG: begin
                if (stop) stop_pend_next = 1'b1;
                // RAM_WORDS is a power of two, so the natural wrap is modulo depth
                wptr_next = wptr_reg + AW'(1);
                if (cnt_reg != '1) cnt_next = cnt_reg + WIDTH'(1);
                if (wptr_reg == WPTR_LAST) ovf_next = 1'b1;
                div_next   = DIV_LOAD;
                state_next = WAIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs decode the registered state only, so they are stable for
    // the whole cycle and go idle as soon as reset forces IDLE.
    always_comb begin
        bus.bus_addr = '0;
        bus.bus_we   = 1'b0;
        bus.bus_wd   = '0;
        case (state_reg)
            CFG_DDR: begin
                bus.bus_addr = ADDR_DDR;
                bus.bus_we   = 1'b1;
                bus.bus_wd   = cfg_ddr;
            end
            CFG_PORT: begin
                bus.bus_addr = ADDR_PORT;
                bus.bus_we   = 1'b1;
                bus.bus_wd   = cfg_port;
            end
            READ: begin
                bus.bus_addr = ADDR_PIN;
            end
            LOG: begin
                bus.bus_addr = WIDTH'(RAM_BASE) + WIDTH'(wptr_reg);
                bus.bus_we   = 1'b1;
                bus.bus_wd   = pin_reg;
            end
            default: begin
                bus.bus_addr = '0;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign last_pin  = pin_reg;
    assign wptr      = wptr_reg;
    assign event_cnt = cnt_reg;
    assign overflow  = ovf_reg;
endmodule
